// File: rtl/seg7_scan_1h.sv
// seg7_scan_1h: 8-digit multiplexed 7-seg driver, one snapshot per frame.
// Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_1h #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic [31:0] data_1h,
  input  logic [7:0]  dp_mask,
  input  logic        display_en,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        frame_done
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_LIT  = PW'(BLANK_CYC);

  logic [PW-1:0] p;
  logic [2:0]    idx;
  logic [31:0]   sh_data;
  logic [7:0]    sh_dp;
  logic          tick;
  logic          snap;
  logic          lit;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [7:0]    seg_d;
  logic [7:0]    an_d;

  assign tick = (p == P_LAST);
  assign snap = tick && (idx == 3'd7);
  assign lit  = display_en && (p >= P_LIT);
  assign nib  = sh_data[{idx, 2'b00} +: 4];

  always_comb begin
    glyph = 7'h3F;
    unique case (nib)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [7:0] lz;
  logic       hi_zero;

  // a digit blanks only while it and every digit above it are zero
  always_comb begin
    lz      = '0;
    hi_zero = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      hi_zero = hi_zero && (sh_data[4*k +: 4] == 4'h0);
      lz[k]   = hi_zero;
    end
  end

  assign blank = lz[idx];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = 8'hFF;
    an_d  = 8'hFF;
    if (lit) begin
      an_d = ~(8'h01 << idx);
      if (!blank) seg_d = {~sh_dp[idx], glyph};
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      p          <= '0;
      idx        <= 3'd0;
      sh_data    <= 32'h0;
      sh_dp      <= 8'h0;
      seg_n      <= 8'hFF;
      an_n       <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      p <= tick ? '0 : p + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if (snap) begin
        sh_data <= data_1h;
        sh_dp   <= dp_mask;
      end
      frame_done <= snap;
      seg_n      <= seg_d;
      an_n       <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_1h.sv
// tb_seg7_scan_1h: directed checks for seg7_scan_1h at DIV=8, BLANK_CYC=2.
// Expected glyphs follow SEG7_LZ_BLANK_EN when it is defined.
module tb_seg7_scan_1h;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk_100MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_1h;
  logic [7:0]  dp_mask;
  logic        display_en;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame_done;

  int cyc;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    int          idx;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t vt[$];

  seg7_scan_1h #(
    .CLK_FREQ_HZ(800),
    .SCAN_HZ(100),
    .BLANK_CYC(2)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .data_1h(data_1h),
    .dp_mask(dp_mask),
    .display_en(display_en),
    .seg_n(seg_n),
    .an_n(an_n),
    .frame_done(frame_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // clocks since reset release; frame position of edge t is (t-1)%64
  always @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    tick();
    while ((cyc % 64) != pos && n < 140) begin
      tick();
      n++;
    end
    if ((cyc % 64) != pos) begin
      total++;
      bad++;
      $display("FAIL wait_pos: got %0d want %0d", cyc % 64, pos);
    end
  endtask

  initial begin
    int n;
    int lit_n;
    int seg_bad;
    int off_bad;
    int fd_n;

    data_1h    = 32'h1234_5678;
    dp_mask    = 8'h00;
    display_en = 1'b1;

    vt.push_back('{32'h1234_5678, 8'h00, 0, 8'hFE, 8'h80});
    vt.push_back('{32'h1234_5678, 8'h00, 7, 8'h7F, 8'hF9});
    vt.push_back('{32'h1234_5678, 8'h01, 0, 8'hFE, 8'h00});
    vt.push_back('{32'h1234_5678, 8'h01, 1, 8'hFD, 8'hF8});
    vt.push_back('{32'h7654_3210, 8'h00, 0, 8'hFE, 8'hC0});
    vt.push_back('{32'h7654_3210, 8'h00, 1, 8'hFD, 8'hF9});
    vt.push_back('{32'h7654_3210, 8'h00, 2, 8'hFB, 8'hA4});
    vt.push_back('{32'h7654_3210, 8'h00, 3, 8'hF7, 8'hB0});
    vt.push_back('{32'h7654_3210, 8'h00, 4, 8'hEF, 8'h99});
    vt.push_back('{32'h7654_3210, 8'h00, 5, 8'hDF, 8'h92});
    vt.push_back('{32'h7654_3210, 8'h00, 6, 8'hBF, 8'h82});
    vt.push_back('{32'h7654_3210, 8'h00, 7, 8'h7F, 8'hF8});
    vt.push_back('{32'h0000_000C, 8'h00, 0, 8'hFE, 8'hBF});
    vt.push_back('{32'h9000_0000, 8'h00, 7, 8'h7F, 8'h90});
    vt.push_back('{32'hF000_0000, 8'h00, 7, 8'h7F, 8'hBF});
    vt.push_back('{32'h0000_0305, 8'h00, 2, 8'hFB, 8'hB0});
    vt.push_back('{32'h0000_0305, 8'h00, 1, 8'hFD, 8'hC0});
    vt.push_back('{32'h0000_0305, 8'h00, 0, 8'hFE, 8'h92});
    vt.push_back('{32'h0000_0305, 8'h00, 3, 8'hF7, LZ ? 8'hFF : 8'hC0});
    vt.push_back('{32'h0000_0305, 8'h00, 7, 8'h7F, LZ ? 8'hFF : 8'hC0});
    vt.push_back('{32'h0000_0305, 8'hFF, 5, 8'hDF, LZ ? 8'hFF : 8'h40});
    vt.push_back('{32'h0000_0000, 8'h00, 0, 8'hFE, 8'hC0});
    vt.push_back('{32'h0000_0000, 8'h00, 4, 8'hEF, LZ ? 8'hFF : 8'hC0});
    vt.push_back('{32'h0000_0000, 8'hFF, 0, 8'hFE, 8'h40});

    // reset state
    #12;
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_fd", frame_done, 1'b0);
    #10 rst_n = 1'b1;

    // first frame shows the reset shadow (zeros)
    wait_pos(5);
    chk("f0_d0_an", an_n, 8'hFE);
    chk("f0_d0_seg", seg_n, 8'hC0);
    wait_pos(29);
    chk("f0_d3_an", an_n, 8'hF7);
    chk("f0_d3_seg", seg_n, LZ ? 8'hFF : 8'hC0);

    n = 0;
    while (!frame_done && n < 200) begin
      tick();
      n++;
    end
    chk("first_fd_cyc", cyc, 64);

    // digit 0 slot: 2 blank clocks then 6 lit
    lit_n = 0;
    seg_bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (an_n === 8'hFE) begin
        lit_n++;
        if (seg_n !== 8'h80) seg_bad++;
      end else if (an_n !== 8'hFF || seg_n !== 8'hFF) begin
        seg_bad++;
      end
    end
    chk("d0_lit_clocks", lit_n, 6);
    chk("d0_seg_errs", seg_bad, 0);
    wait_pos(13);
    chk("d1_an", an_n, 8'hFD);
    chk("d1_seg", seg_n, 8'hF8);

    // mid-frame change stays invisible until the next snapshot
    wait_pos(26);
    data_1h = 32'h8765_4321;
    wait_pos(45);
    chk("snap_old_an", an_n, 8'hDF);
    chk("snap_old_seg", seg_n, 8'hB0);
    wait_pos(0);
    chk("snap_fd", frame_done, 1'b1);
    wait_pos(45);
    chk("snap_new_seg", seg_n, 8'h82);
    wait_pos(5);
    chk("snap_new_d0", seg_n, 8'hF9);

    for (int i = 0; i < vt.size(); i++) begin
      data_1h = vt[i].data;
      dp_mask = vt[i].dp;
      wait_pos(0);
      chk($sformatf("vec%0d_fd", i), frame_done, 1'b1);
      wait_pos(1 + vt[i].idx * 8 + 4);
      chk($sformatf("vec%0d_an", i), an_n, vt[i].an);
      chk($sformatf("vec%0d_seg", i), seg_n, vt[i].seg);
    end

    // disabled for one full frame; scanning and snapshots continue
    wait_pos(0);
    display_en = 1'b0;
    off_bad = 0;
    fd_n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (an_n !== 8'hFF || seg_n !== 8'hFF) off_bad++;
      if (frame_done === 1'b1) fd_n++;
    end
    chk("dis_dark", off_bad, 0);
    chk("dis_fd_count", fd_n, 1);
    chk("dis_fd_phase", frame_done, 1'b1);
    display_en = 1'b1;
    wait_pos(17);
    chk("reen_blank_an", an_n, 8'hFF);
    wait_pos(19);
    chk("reen_lit_an", an_n, 8'hFB);
    wait_pos(21);
    chk("pre_rst_an", an_n, 8'hFB);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an_n, 8'hFF);
    chk("arst_seg", seg_n, 8'hFF);
    chk("arst_fd", frame_done, 1'b0);
    #3 rst_n = 1'b1;
    n = 0;
    while (cyc < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("post_rst_cyc2_an", an_n, 8'hFF);
    tick();
    chk("post_rst_an", an_n, 8'hFE);
    chk("post_rst_seg", seg_n, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
